// File: rtl/dma_ctrl_sequencer_if.sv
// Bus bundle between the sequencer and its instruction store / memory-IO side.
//   instr_addr  : program counter driven by the sequencer
//   instr_req   : instruction fetch request
//   instr_valid : instr_data valid, completes the fetch
//   instr_data  : 24-bit instruction word
//   mem_addr    : lw/sw address
//   mem_req     : memory/IO request, held until mem_ack
//   mem_we      : 1 = store, 0 = load
//   io_sel      : 1 selects the IO device, 0 selects memory
//   mem_ack     : completes a memory/IO transfer
// master = sequencer side, slave = instruction store / memory side.
interface dma_ctrl_sequencer_if #(
  parameter int PC_W = 8
);
  logic [PC_W-1:0] instr_addr;
  logic            instr_req;
  logic            instr_valid;
  logic [23:0]     instr_data;
  logic [7:0]      mem_addr;
  logic            mem_req;
  logic            mem_we;
  logic            io_sel;
  logic            mem_ack;

  modport master (
    output instr_addr, instr_req, mem_addr, mem_req, mem_we, io_sel,
    input  instr_valid, instr_data, mem_ack
  );

  modport slave (
    input  instr_addr, instr_req, mem_addr, mem_req, mem_we, io_sel,
    output instr_valid, instr_data, mem_ack
  );
endinterface

// File: rtl/dma_ctrl_sequencer.sv
// Fetch/decode/sequence stage feeding the register file. Fetches 24-bit words,
// decodes them into register-file controls and runs the lw/sw memory/IO
// handshake, from a start pulse until HALT or an error (fetch/ack timeout or
// illegal opcode).
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   start             : 1-cycle pulse, starts at PC=0 when idle
//   bus               : instruction fetch and memory/IO handshake (master side)
//   op, op_type       : decoded opcode and type (op_type = instr[21:20])
//   Readreg1/2        : rs1 / rs2
//   Writereg          : rd for ALU ops
//   next_source       : {4'b0,rd}, store source register
//   destination       : {4'b0,rd}, load destination register
//   RegWrite          : register file write enable (EXEC and WB only)
//   busy, done, err   : running, HALT retire pulse, sticky error
//   instr_count       : retired instructions incl. HALT, saturating
module dma_ctrl_sequencer #(
  parameter int PC_W    = 8,
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  dma_ctrl_sequencer_if.master  bus,
  output logic [1:0]            op,
  output logic [1:0]            op_type,
  output logic [3:0]            Readreg1,
  output logic [3:0]            Readreg2,
  output logic [3:0]            Writereg,
  output logic [7:0]            next_source,
  output logic [7:0]            destination,
  output logic                  RegWrite,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [CNT_W-1:0]      instr_count
);
  localparam int TCNT_W = $clog2(TIMEOUT + 1);
  localparam logic [TCNT_W-1:0] TLAST = TCNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, MEM, WB} state_t;

  state_t            state, state_nx;
  logic [PC_W-1:0]   pc;
  logic [TCNT_W-1:0] tcnt;
  logic [7:0]        mem_addr_r;
  logic              start_acc, capture, retire, adv_pc, fault;
  logic              instr_req, mem_req, mem_we, io_sel;
  logic              tmo;

  // tcnt counts completed cycles in the current state; the TIMEOUT-th cycle
  // still accepts instr_valid / mem_ack before faulting.
  assign tmo = (tcnt == TLAST);

  assign bus.instr_addr = pc;
  assign bus.instr_req  = instr_req;
  assign bus.mem_addr   = mem_addr_r;
  assign bus.mem_req    = mem_req;
  assign bus.mem_we     = mem_we;
  assign bus.io_sel     = io_sel;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    start_acc = 1'b0;
    capture   = 1'b0;
    retire    = 1'b0;
    adv_pc    = 1'b0;
    fault     = 1'b0;
    done      = 1'b0;
    RegWrite  = 1'b0;
    instr_req = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    io_sel    = 1'b0;
    busy      = (state != IDLE);
    case (state)
      IDLE: begin
        if (start) begin
          start_acc = 1'b1;
          state_nx  = FETCH;
        end
      end
      FETCH: begin
        instr_req = 1'b1;
        if (bus.instr_valid) begin
          capture  = 1'b1;
          state_nx = DECODE;
        end else if (tmo) begin
          fault    = 1'b1;
          state_nx = IDLE;
        end
      end
      DECODE: begin
        if (op == 2'b00 && op_type == 2'b01) begin
          done     = 1'b1;
          retire   = 1'b1;
          state_nx = IDLE;
        end else if (!op[1] && op_type == 2'b10) begin
          fault    = 1'b1;
          state_nx = IDLE;
        end else if (op[1]) begin
          state_nx = EXEC;
        end else begin
          state_nx = MEM;
        end
      end
      EXEC: begin
        RegWrite = 1'b1;
        retire   = 1'b1;
        adv_pc   = 1'b1;
        state_nx = FETCH;
      end
      MEM: begin
        mem_req = 1'b1;
        mem_we  = (op == 2'b00);
        io_sel  = (op_type == 2'b11);
        if (bus.mem_ack) begin
          if (op == 2'b00) begin
            retire   = 1'b1;
            adv_pc   = 1'b1;
            state_nx = FETCH;
          end else begin
            state_nx = WB;
          end
        end else if (tmo) begin
          fault    = 1'b1;
          state_nx = IDLE;
        end
      end
      WB: begin
        RegWrite = 1'b1;
        retire   = 1'b1;
        adv_pc   = 1'b1;
        state_nx = FETCH;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= '0;
      tcnt        <= '0;
      err         <= 1'b0;
      instr_count <= '0;
      op          <= 2'b00;
      op_type     <= 2'b01;
      Readreg1    <= '0;
      Readreg2    <= '0;
      Writereg    <= '0;
      next_source <= '0;
      destination <= '0;
      mem_addr_r  <= '0;
    end else begin
      if (state_nx != state)  tcnt <= '0;
      else if (tcnt != TLAST) tcnt <= tcnt + TCNT_W'(1);

      if (start_acc) begin
        pc          <= '0;
        err         <= 1'b0;
        instr_count <= '0;
      end
      if (fault) err <= 1'b1;
      if (retire && instr_count != '1) instr_count <= instr_count + CNT_W'(1);
      if (adv_pc) pc <= pc + PC_W'(1);

      // Fetch -> decode boundary: fields stay frozen until the next fetch.
      if (capture) begin
        op          <= bus.instr_data[23:22];
        op_type     <= bus.instr_data[21:20];
        Writereg    <= bus.instr_data[19:16];
        next_source <= {4'b0, bus.instr_data[19:16]};
        destination <= {4'b0, bus.instr_data[19:16]};
        Readreg1    <= bus.instr_data[15:12];
        Readreg2    <= bus.instr_data[11:8];
        mem_addr_r  <= bus.instr_data[7:0];
      end

      // Leaving for IDLE parks op/type on the neutral HALT encoding.
      if (state_nx == IDLE && state != IDLE) begin
        op      <= 2'b00;
        op_type <= 2'b01;
      end
    end
  end
endmodule

// File: tb/tb_dma_ctrl_sequencer.sv
module tb_dma_ctrl_sequencer;
  localparam int PC_W    = 8;
  localparam int TIMEOUT = 15;
  localparam int CNT_W   = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  always #5 clk = ~clk;

  dma_ctrl_sequencer_if #(.PC_W(PC_W)) bus ();

  logic [1:0]       op, op_type;
  logic [3:0]       Readreg1, Readreg2, Writereg;
  logic [7:0]       next_source, destination;
  logic             RegWrite, busy, done, err;
  logic [CNT_W-1:0] instr_count;

  dma_ctrl_sequencer #(.PC_W(PC_W), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .bus(bus),
    .op(op), .op_type(op_type), .Readreg1(Readreg1), .Readreg2(Readreg2),
    .Writereg(Writereg), .next_source(next_source), .destination(destination),
    .RegWrite(RegWrite), .busy(busy), .done(done), .err(err),
    .instr_count(instr_count)
  );

  int ncmp = 0;
  int nfail = 0;

  typedef struct { logic [1:0] op; logic [3:0] rg; } wexp_t;
  typedef struct { logic [7:0] addr; logic we; logic io; logic [3:0] rg; } mexp_t;
  wexp_t wq[$];
  mexp_t mq[$];
  logic  mreq_q = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Waits (bounded) for a fetch request, then answers it in the same cycle.
  task automatic give_instr(input logic [23:0] w);
    int n = 0;
    while (!bus.instr_req && n < 40) begin
      tick();
      n++;
    end
    chk("fetch_req_seen", 32'(bus.instr_req), 32'd1);
    bus.instr_valid = 1'b1;
    bus.instr_data  = w;
    tick();
    bus.instr_valid = 1'b0;
    bus.instr_data  = '0;
  endtask

  task automatic push_w(input logic [1:0] o, input logic [3:0] r);
    wexp_t e;
    e.op = o;
    e.rg = r;
    wq.push_back(e);
  endtask

  task automatic push_m(input logic [7:0] a, input logic we, input logic io, input logic [3:0] r);
    mexp_t e;
    e.addr = a;
    e.we   = we;
    e.io   = io;
    e.rg   = r;
    mq.push_back(e);
  endtask

  // Scoreboard: register writes and memory requests as the DUT emits them.
  always @(negedge clk) begin
    mreq_q <= bus.mem_req;
    if (rst_n) begin
      if (RegWrite) begin
        chk("rw_expected", 32'(wq.size() != 0), 32'd1);
        if (wq.size() != 0) begin
          chk("rw_op", 32'(op), 32'(wq[0].op));
          chk("rw_reg", (wq[0].op == 2'b01) ? 32'(destination) : 32'(Writereg), 32'(wq[0].rg));
          void'(wq.pop_front());
        end
      end
      if (bus.mem_req && !mreq_q) begin
        chk("mreq_expected", 32'(mq.size() != 0), 32'd1);
        if (mq.size() != 0) begin
          chk("mreq_addr", 32'(bus.mem_addr), 32'(mq[0].addr));
          chk("mreq_we", 32'(bus.mem_we), 32'(mq[0].we));
          chk("mreq_io", 32'(bus.io_sel), 32'(mq[0].io));
          chk("mreq_reg", mq[0].we ? 32'(next_source) : 32'(destination), 32'(mq[0].rg));
          void'(mq.pop_front());
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.instr_valid = 1'b0;
    bus.instr_data  = '0;
    bus.mem_ack     = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_instr_req", 32'(bus.instr_req), 32'd0);
    chk("rst_mem_req", 32'(bus.mem_req), 32'd0);
    chk("rst_op", 32'(op), 32'd0);
    chk("rst_type", 32'(op_type), 32'd1);
    chk("rst_count", 32'(instr_count), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_pc", 32'(bus.instr_addr), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    rst_n = 1'b1;
    tick();

    // T1 add r3 = r1 + r2
    do_start();
    chk("t1_busy", 32'(busy), 32'd1);
    push_w(2'b10, 4'd3);
    give_instr({2'b10, 2'b00, 4'd3, 4'd1, 4'd2, 8'h00});
    chk("t1_dec_op", 32'(op), 32'd2);
    chk("t1_dec_rs1", 32'(Readreg1), 32'd1);
    chk("t1_dec_rs2", 32'(Readreg2), 32'd2);
    chk("t1_dec_rd", 32'(Writereg), 32'd3);
    chk("t1_dec_rw", 32'(RegWrite), 32'd0);
    tick();
    chk("t1_exec_rw", 32'(RegWrite), 32'd1);
    tick();
    chk("t1_rw_low", 32'(RegWrite), 32'd0);
    chk("t1_count", 32'(instr_count), 32'd1);
    chk("t1_pc", 32'(bus.instr_addr), 32'd1);

    // T2 lw r5 <- [0x20], ack in the third MEM cycle
    push_m(8'h20, 1'b0, 1'b0, 4'd5);
    push_w(2'b01, 4'd5);
    give_instr({2'b01, 2'b00, 4'd5, 4'd0, 4'd0, 8'h20});
    tick();
    chk("t2_req_c1", 32'(bus.mem_req), 32'd1);
    chk("t2_addr", 32'(bus.mem_addr), 32'h20);
    chk("t2_we", 32'(bus.mem_we), 32'd0);
    tick();
    chk("t2_req_c2", 32'(bus.mem_req), 32'd1);
    tick();
    chk("t2_req_c3", 32'(bus.mem_req), 32'd1);
    bus.mem_ack = 1'b1;
    tick();
    bus.mem_ack = 1'b0;
    chk("t2_req_drop", 32'(bus.mem_req), 32'd0);
    chk("t2_wb_rw", 32'(RegWrite), 32'd1);
    chk("t2_wb_dest", 32'(destination), 32'd5);
    chk("t2_wb_op", 32'(op), 32'd1);
    tick();
    chk("t2_count", 32'(instr_count), 32'd2);
    chk("t2_pc", 32'(bus.instr_addr), 32'd2);

    // T3 sw r7 -> IO[0x40]
    push_m(8'h40, 1'b1, 1'b1, 4'd7);
    give_instr({2'b00, 2'b11, 4'd7, 4'd0, 4'd0, 8'h40});
    tick();
    chk("t3_we", 32'(bus.mem_we), 32'd1);
    chk("t3_io", 32'(bus.io_sel), 32'd1);
    chk("t3_src", 32'(next_source), 32'd7);
    chk("t3_rw", 32'(RegWrite), 32'd0);
    bus.mem_ack = 1'b1;
    tick();
    bus.mem_ack = 1'b0;
    chk("t3_req_drop", 32'(bus.mem_req), 32'd0);
    chk("t3_count", 32'(instr_count), 32'd3);
    chk("t3_pc", 32'(bus.instr_addr), 32'd3);

    // T4 HALT
    give_instr({2'b00, 2'b01, 4'd0, 4'd0, 4'd0, 8'h00});
    chk("t4_done", 32'(done), 32'd1);
    tick();
    chk("t4_done_pulse", 32'(done), 32'd0);
    chk("t4_busy", 32'(busy), 32'd0);
    chk("t4_count", 32'(instr_count), 32'd4);
    chk("t4_op", 32'(op), 32'd0);
    chk("t4_type", 32'(op_type), 32'd1);

    // Illegal opcode: lw with type 10
    do_start();
    give_instr({2'b01, 2'b10, 4'd1, 4'd0, 4'd0, 8'h11});
    chk("ill_done", 32'(done), 32'd0);
    tick();
    chk("ill_err", 32'(err), 32'd1);
    chk("ill_busy", 32'(busy), 32'd0);
    chk("ill_count", 32'(instr_count), 32'd0);

    // T5 lw with no ack -> timeout
    do_start();
    chk("t5_err_clr", 32'(err), 32'd0);
    push_m(8'h10, 1'b0, 1'b0, 4'd4);
    give_instr({2'b01, 2'b00, 4'd4, 4'd0, 4'd0, 8'h10});
    tick();
    repeat (TIMEOUT - 1) tick();
    chk("t5_req_last", 32'(bus.mem_req), 32'd1);
    chk("t5_err_last", 32'(err), 32'd0);
    tick();
    chk("t5_err", 32'(err), 32'd1);
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_req", 32'(bus.mem_req), 32'd0);
    chk("t5_count", 32'(instr_count), 32'd0);
    do_start();
    chk("t5_restart_err", 32'(err), 32'd0);
    chk("t5_restart_busy", 32'(busy), 32'd1);

    // Ack on the TIMEOUT-th MEM cycle still succeeds
    push_m(8'h33, 1'b1, 1'b0, 4'd2);
    give_instr({2'b00, 2'b00, 4'd2, 4'd0, 4'd0, 8'h33});
    tick();
    repeat (TIMEOUT - 1) tick();
    bus.mem_ack = 1'b1;
    tick();
    bus.mem_ack = 1'b0;
    chk("edge_ack_err", 32'(err), 32'd0);
    chk("edge_ack_count", 32'(instr_count), 32'd1);
    chk("edge_ack_busy", 32'(busy), 32'd1);

    // Fetch timeout: no instr_valid for TIMEOUT cycles
    repeat (TIMEOUT - 1) tick();
    chk("ftmo_req_last", 32'(bus.instr_req), 32'd1);
    chk("ftmo_err_last", 32'(err), 32'd0);
    tick();
    chk("ftmo_err", 32'(err), 32'd1);
    chk("ftmo_req", 32'(bus.instr_req), 32'd0);
    chk("ftmo_busy", 32'(busy), 32'd0);

    // T6 asynchronous reset during MEM
    do_start();
    push_w(2'b10, 4'd9);
    give_instr({2'b10, 2'b00, 4'd9, 4'd4, 4'd5, 8'h00});
    tick();
    tick();
    push_m(8'h55, 1'b0, 1'b0, 4'd6);
    give_instr({2'b01, 2'b00, 4'd6, 4'd0, 4'd0, 8'h55});
    tick();
    chk("t6_pre_req", 32'(bus.mem_req), 32'd1);
    chk("t6_pre_count", 32'(instr_count), 32'd1);
    #6;
    rst_n = 1'b0;
    #1;
    chk("t6_req", 32'(bus.mem_req), 32'd0);
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_op", 32'(op), 32'd0);
    chk("t6_type", 32'(op_type), 32'd1);
    chk("t6_pc", 32'(bus.instr_addr), 32'd0);
    chk("t6_count", 32'(instr_count), 32'd0);
    chk("t6_rs1", 32'(Readreg1), 32'd0);
    chk("t6_dest", 32'(destination), 32'd0);
    chk("t6_addr", 32'(bus.mem_addr), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("t6_idle", 32'(busy), 32'd0);

    chk("wq_drained", 32'(wq.size()), 32'd0);
    chk("mq_drained", 32'(mq.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
